// File: rtl/cache_axi_arbiter.sv
// rtl/cache_axi_arbiter.sv - N-client cache line fill/writeback arbiter onto one AXI4 master port
//
// Purpose: round-robin arbitration of cache-line fills (AR/R) and writebacks (AW/W/B) from
// N_CLIENTS caches. Each line is one INCR burst of BEATS beats, one transaction outstanding.
// Snoop invalidates (AC) are accepted only while idle and broadcast on inv_valid/inv_addr.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req_valid/store/addr/wdata     per-client line requests (wdata beat k at [k*DW +: DW])
//   req_ready                      one-hot accept pulse
//   resp_valid, resp_rdata         one-hot completion pulse, shared fill line
//   inv_valid, inv_addr            line-aligned snoop invalidate broadcast
//   m_axi_ar*/r*/aw*/w*/b*/ac*     AXI4 master read, write and snoop channels
//   stat_grants, stat_busy         saturating counters, present only with CACHE_ARB_STATS_EN
//
// Optional feature macro: CACHE_ARB_STATS_EN

module cache_axi_arbiter #(
    parameter int N_CLIENTS  = 2,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 13,
    parameter int BEATS      = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [N_CLIENTS-1:0]                   req_valid,
    input  logic [N_CLIENTS-1:0]                   req_store,
    input  logic [N_CLIENTS*ADDR_WIDTH-1:0]        req_addr,
    input  logic [N_CLIENTS*BEATS*DATA_WIDTH-1:0]  req_wdata,
    output logic [N_CLIENTS-1:0]                   req_ready,
    output logic [N_CLIENTS-1:0]                   resp_valid,
    output logic [BEATS*DATA_WIDTH-1:0]            resp_rdata,
    output logic                                   inv_valid,
    output logic [ADDR_WIDTH-1:0]                  inv_addr,
    output logic [ID_WIDTH-1:0]                    m_axi_arid,
    output logic [ADDR_WIDTH-1:0]                  m_axi_araddr,
    output logic [7:0]                             m_axi_arlen,
    output logic [2:0]                             m_axi_arsize,
    output logic [1:0]                             m_axi_arburst,
    output logic                                   m_axi_arvalid,
    input  logic                                   m_axi_arready,
    input  logic [ID_WIDTH-1:0]                    m_axi_rid,
    input  logic [DATA_WIDTH-1:0]                  m_axi_rdata,
    input  logic [1:0]                             m_axi_rresp,
    input  logic                                   m_axi_rlast,
    input  logic                                   m_axi_rvalid,
    output logic                                   m_axi_rready,
    output logic [ID_WIDTH-1:0]                    m_axi_awid,
    output logic [ADDR_WIDTH-1:0]                  m_axi_awaddr,
    output logic [7:0]                             m_axi_awlen,
    output logic [2:0]                             m_axi_awsize,
    output logic [1:0]                             m_axi_awburst,
    output logic                                   m_axi_awvalid,
    input  logic                                   m_axi_awready,
    output logic [DATA_WIDTH-1:0]                  m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]                m_axi_wstrb,
    output logic                                   m_axi_wlast,
    output logic                                   m_axi_wvalid,
    input  logic                                   m_axi_wready,
    input  logic [ID_WIDTH-1:0]                    m_axi_bid,
    input  logic [1:0]                             m_axi_bresp,
    input  logic                                   m_axi_bvalid,
    output logic                                   m_axi_bready,
    input  logic                                   m_axi_acvalid,
    input  logic [ADDR_WIDTH-1:0]                  m_axi_acaddr,
    input  logic [3:0]                             m_axi_acsnoop,
    output logic                                   m_axi_acready
`ifdef CACHE_ARB_STATS_EN
    ,
    output logic [N_CLIENTS*32-1:0]                stat_grants,
    output logic [31:0]                            stat_busy
`endif
);

    localparam int LINE       = BEATS * DATA_WIDTH;
    localparam int LINE_BYTES = LINE / 8;
    localparam int CLW        = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int CW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(LINE_BYTES - 1));
    localparam logic [2:0]            AXSIZE    = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [7:0]            AXLEN     = 8'(BEATS - 1);
    localparam logic [CW-1:0]         LAST_BEAT = CW'(BEATS - 1);
    localparam logic [CLW-1:0]        LAST_CLI  = CLW'(N_CLIENTS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
    } state_t;

    state_t                  state, state_next;
    logic [CLW-1:0]          rr_q, client_q, gidx;
    logic                    found, grant, take_snoop, store_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE-1:0]         wbuf_q, rbuf_q;
    logic [CW-1:0]           beat_q;
    int                      cand;

    // Ignored response/ID fields are folded here so they are visibly consumed.
    logic unused_inputs;
    assign unused_inputs = ^{m_axi_rid, m_axi_rresp, m_axi_bid, m_axi_bresp, m_axi_acsnoop};

    // First requesting client at or after the round-robin pointer, wrapping.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = 0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= N_CLIENTS) cand = cand - N_CLIENTS;
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                gidx  = CLW'(cand);
            end
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        take_snoop = 1'b0;
        case (state)
            S_IDLE: begin
                // Reset gating keeps req_ready/acready low while reset is held.
                if (!reset) begin
                    if (m_axi_acvalid) begin
                        take_snoop = 1'b1;
                    end else if (found) begin
                        grant      = 1'b1;
                        state_next = req_store[gidx] ? S_AW : S_AR;
                    end
                end
            end
            S_AR:    if (m_axi_arready) state_next = S_R;
            S_R:     if (m_axi_rvalid && m_axi_rlast) state_next = S_DONE;
            S_AW:    if (m_axi_awready) state_next = S_W;
            S_W:     if (m_axi_wready && beat_q == LAST_BEAT) state_next = S_B;
            S_B:     if (m_axi_bvalid) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready       = '0;
        req_ready[gidx] = grant;
    end

    assign m_axi_acready = take_snoop;

    assign m_axi_arid    = ID_WIDTH'(client_q);
    assign m_axi_araddr  = addr_q & LINE_MASK;
    assign m_axi_arlen   = AXLEN;
    assign m_axi_arsize  = AXSIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state == S_AR);
    assign m_axi_rready  = (state == S_R);

    assign m_axi_awid    = ID_WIDTH'(client_q);
    assign m_axi_awaddr  = addr_q & LINE_MASK;
    assign m_axi_awlen   = AXLEN;
    assign m_axi_awsize  = AXSIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = (state == S_AW);

    assign m_axi_wdata   = wbuf_q[beat_q*DATA_WIDTH +: DATA_WIDTH];
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (beat_q == LAST_BEAT);
    assign m_axi_wvalid  = (state == S_W);
    assign m_axi_bready  = (state == S_B);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rr_q       <= '0;
            client_q   <= '0;
            store_q    <= 1'b0;
            addr_q     <= '0;
            wbuf_q     <= '0;
            rbuf_q     <= '0;
            beat_q     <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            inv_valid  <= 1'b0;
            inv_addr   <= '0;
        end else begin
            state      <= state_next;
            resp_valid <= '0;
            inv_valid  <= take_snoop;
            if (take_snoop) inv_addr <= m_axi_acaddr & LINE_MASK;

            if (grant) begin
                client_q <= gidx;
                store_q  <= req_store[gidx];
                addr_q   <= req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
                wbuf_q   <= req_wdata[gidx*LINE +: LINE];
                rr_q     <= (gidx == LAST_CLI) ? '0 : gidx + 1'b1;
            end

            case (state)
                S_R: if (m_axi_rvalid) begin
                    rbuf_q[beat_q*DATA_WIDTH +: DATA_WIDTH] <= m_axi_rdata;
                    // An early rlast still ends the burst; the counter restarts for the next line.
                    beat_q <= m_axi_rlast ? '0 : beat_q + 1'b1;
                end
                S_W: if (m_axi_wready) begin
                    beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
                end
                S_DONE: begin
                    resp_valid[client_q] <= 1'b1;
                    // Only fills refresh the shared line; writebacks leave the last fill visible.
                    if (!store_q) resp_rdata <= rbuf_q;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grants <= '0;
            stat_busy   <= '0;
        end else begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (grant && gidx == CLW'(i) && stat_grants[i*32 +: 32] != 32'hFFFF_FFFF)
                    stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
            end
            if (state != S_IDLE && stat_busy != 32'hFFFF_FFFF)
                stat_busy <= stat_busy + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb/tb_cache_axi_arbiter.sv - directed self-checking bench for cache_axi_arbiter

module tb_cache_axi_arbiter;

    localparam int N     = 2;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int IW    = 13;
    localparam int BEATS = 8;
    localparam int LINE  = BEATS * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                  reset;
    logic [N-1:0]          req_valid, req_store, req_ready, resp_valid;
    logic [N*AW-1:0]       req_addr;
    logic [N*LINE-1:0]     req_wdata;
    logic [LINE-1:0]       resp_rdata;
    logic                  inv_valid;
    logic [AW-1:0]         inv_addr;
    logic [IW-1:0]         m_axi_arid, m_axi_rid, m_axi_awid, m_axi_bid;
    logic [AW-1:0]         m_axi_araddr, m_axi_awaddr, m_axi_acaddr;
    logic [7:0]            m_axi_arlen, m_axi_awlen;
    logic [2:0]            m_axi_arsize, m_axi_awsize;
    logic [1:0]            m_axi_arburst, m_axi_awburst, m_axi_rresp, m_axi_bresp;
    logic                  m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic                  m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic                  m_axi_bvalid, m_axi_bready, m_axi_acvalid, m_axi_acready;
    logic [DW-1:0]         m_axi_rdata, m_axi_wdata;
    logic [DW/8-1:0]       m_axi_wstrb;
    logic [3:0]            m_axi_acsnoop;
`ifdef CACHE_ARB_STATS_EN
    logic [N*32-1:0]       stat_grants;
    logic [31:0]           stat_busy;
`endif

    cache_axi_arbiter #(.N_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_store(req_store), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .inv_valid(inv_valid), .inv_addr(inv_addr),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_acvalid(m_axi_acvalid), .m_axi_acaddr(m_axi_acaddr), .m_axi_acsnoop(m_axi_acsnoop),
        .m_axi_acready(m_axi_acready)
`ifdef CACHE_ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_busy(stat_busy)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic grant_wait(output logic [N-1:0] g);
        int n;
        n = 0;
        #1;
        while (req_ready === '0 && n < 20) begin
            tick;
            n++;
        end
        g = req_ready;
    endtask

    // Zero-wait read slave for one line; leaves time at the resp_valid cycle.
    task automatic serve_fill(input int c, input logic [63:0] ea, input logic [63:0] base, output int rc);
        int n;
        n = 0;
        while (m_axi_arvalid !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk("arvalid", m_axi_arvalid, 1);
        m_axi_arready = 1'b1;
        #1;
        chk("araddr", m_axi_araddr, ea);
        chk("arlen", m_axi_arlen, 7);
        chk("arid", m_axi_arid, 64'(c));
        chk("arsize", m_axi_arsize, 3);
        chk("arburst", m_axi_arburst, 1);
        tick;
        m_axi_arready = 1'b0;
        chk("rready", m_axi_rready, 1);
        for (int k = 0; k < BEATS; k++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = base + 64'(k);
            m_axi_rlast  = (k == BEATS - 1);
            tick;
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        n = 0;
        while (resp_valid === '0 && n < 20) begin
            tick;
            n++;
        end
        rc = cyc;
        chk("resp_valid", resp_valid, 64'(1) << c);
        chk("rdata_beat0", resp_rdata[63:0], base);
        chk("rdata_beat7", resp_rdata[511:448], base + 64'd7);
    endtask

    logic [N-1:0] g;
    logic [N-1:0] seen;
    int gc, rc;

    initial begin
        reset = 1'b1;
        req_valid = '0; req_store = '0; req_addr = '0; req_wdata = '0;
        m_axi_arready = 0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
        m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_bid = '0; m_axi_bresp = '0;
        m_axi_bvalid = 0; m_axi_acvalid = 0; m_axi_acaddr = '0; m_axi_acsnoop = '0;
        tick; tick;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata[63:0], 0);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_inv_valid", inv_valid, 0);
        reset = 1'b0;

        // 1: fill by client 1, grant-to-resp latency BEATS+3
        req_addr[AW +: AW] = 64'h8000_1234;
        req_valid = 2'b10;
        grant_wait(g);
        gc = cyc;
        chk("t1_grant", g, 2'b10);
        tick;
        req_valid = '0;
        serve_fill(1, 64'h8000_1200, 64'h10, rc);
        chk("t1_latency", 64'(rc - gc), 11);
        tick;
        chk("t1_resp_once", resp_valid, 0);

        // 2: writeback by client 0 with awready delayed 3 cycles
        for (int k = 0; k < BEATS; k++) req_wdata[k*DW +: DW] = 64'hA0 + 64'(k);
        req_addr[0 +: AW] = 64'h40;
        req_store = 2'b01;
        req_valid = 2'b01;
        grant_wait(g);
        chk("t2_grant", g, 2'b01);
        tick;
        req_valid = '0;
        req_store = '0;
        chk("t2_awvalid", m_axi_awvalid, 1);
        chk("t2_awaddr", m_axi_awaddr, 64'h40);
        chk("t2_awlen", m_axi_awlen, 7);
        chk("t2_awid", m_axi_awid, 0);
        chk("t2_wvalid_early", m_axi_wvalid, 0);
        for (int d = 0; d < 3; d++) begin
            tick;
            chk("t2_aw_hold", m_axi_awvalid, 1);
        end
        m_axi_awready = 1'b1;
        tick;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b1;
        #1;
        chk("t2_wstrb", m_axi_wstrb, 8'hFF);
        for (int k = 0; k < BEATS; k++) begin
            chk("t2_wvalid", m_axi_wvalid, 1);
            chk("t2_wdata", m_axi_wdata, 64'hA0 + 64'(k));
            chk("t2_wlast", m_axi_wlast, 64'(k == BEATS - 1));
            tick;
        end
        m_axi_wready = 1'b0;
        chk("t2_bready", m_axi_bready, 1);
        chk("t2_resp_before_b", resp_valid, 0);
        m_axi_bvalid = 1'b1;
        tick;
        m_axi_bvalid = 1'b0;
        tick;
        chk("t2_resp_valid", resp_valid, 2'b01);
        chk("t2_rdata_kept", resp_rdata[63:0], 64'h10);

        // 3: both clients request continuously from reset -> 0,1,0,1
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        req_addr[0 +: AW]  = 64'h1000;
        req_addr[AW +: AW] = 64'h2000;
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            grant_wait(g);
            chk("t3_grant", g, (t % 2 == 1) ? 2'b10 : 2'b01);
            tick;
            if (t == 3) req_valid = '0;
            serve_fill(t % 2, (t % 2 == 1) ? 64'h2000 : 64'h1000, 64'h100 * 64'(t + 1), rc);
        end

        // 4: snoop during R burst waits for IDLE, then pending client 1 is granted
        tick;
        req_addr[0 +: AW] = 64'h3000;
        req_valid = 2'b01;
        grant_wait(g);
        chk("t4_grant0", g, 2'b01);
        tick;
        req_valid = 2'b10;
        m_axi_arready = 1'b1;
        tick;
        m_axi_arready = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            if (k == 3) begin
                m_axi_acvalid = 1'b1;
                m_axi_acaddr  = 64'h1238;
            end
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 64'h200 + 64'(k);
            m_axi_rlast  = (k == BEATS - 1);
            #1;
            if (k >= 3) chk("t4_acready_busy", m_axi_acready, 0);
            tick;
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        chk("t4_acready_done", m_axi_acready, 0);
        tick;
        chk("t4_resp_valid", resp_valid, 2'b01);
        chk("t4_acready_idle", m_axi_acready, 1);
        chk("t4_no_grant", req_ready, 0);
        tick;
        m_axi_acvalid = 1'b0;
        #1;
        chk("t4_inv_valid", inv_valid, 1);
        chk("t4_inv_addr", inv_addr, 64'h1200);
        chk("t4_grant1", req_ready, 2'b10);
        tick;
        chk("t4_inv_once", inv_valid, 0);
        req_valid = '0;
        serve_fill(1, 64'h2000, 64'h300, rc);

        // 5: reset on beat 3 of a fill
        tick;
        req_addr[0 +: AW] = 64'h5000;
        req_valid = 2'b01;
        grant_wait(g);
        chk("t5_grant", g, 2'b01);
        tick;
        req_valid = '0;
        m_axi_arready = 1'b1;
        tick;
        m_axi_arready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 64'h400 + 64'(k);
            tick;
        end
        m_axi_rdata = 64'h403;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        m_axi_rvalid = 1'b0;
        #1;
        chk("t5_arvalid", m_axi_arvalid, 0);
        chk("t5_rready", m_axi_rready, 0);
        chk("t5_awvalid", m_axi_awvalid, 0);
        chk("t5_wvalid", m_axi_wvalid, 0);
        chk("t5_resp_valid", resp_valid, 0);
        chk("t5_resp_rdata", resp_rdata[63:0], 0);
        seen = '0;
        for (int k = 0; k < 12; k++) begin
            tick;
            seen = seen | resp_valid;
        end
        chk("t5_no_resp", seen, 0);
        req_valid = 2'b11;
        grant_wait(g);
        chk("t5_rr_reset", g, 2'b01);
        tick;
        req_valid = '0;
        serve_fill(0, 64'h5000, 64'h500, rc);

`ifdef CACHE_ARB_STATS_EN
        // 6: five fills by client 1
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        req_addr[AW +: AW] = 64'h6000;
        for (int t = 0; t < 5; t++) begin
            req_valid = 2'b10;
            grant_wait(g);
            chk("t6_grant", g, 2'b10);
            tick;
            req_valid = '0;
            serve_fill(1, 64'h6000, 64'h600, rc);
            tick;
        end
        chk("t6_grants1", stat_grants[63:32], 5);
        chk("t6_grants0", stat_grants[31:0], 0);
        chk("t6_busy", stat_busy, 50);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
